// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing, mode encoding and colour constants
package vga_pkg;

    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;
    localparam int VGA_BOX    = 32;
    localparam int VGA_CNT_W  = 11;

    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_BOX     = 2'd2,
        MODE_SOLID   = 2'd3
    } mode_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t C_WHITE   = rgb_t'(12'hFFF);
    localparam rgb_t C_YELLOW  = rgb_t'(12'hFF0);
    localparam rgb_t C_CYAN    = rgb_t'(12'h0FF);
    localparam rgb_t C_GREEN   = rgb_t'(12'h0F0);
    localparam rgb_t C_MAGENTA = rgb_t'(12'hF0F);
    localparam rgb_t C_RED     = rgb_t'(12'hF00);
    localparam rgb_t C_BLUE    = rgb_t'(12'h00F);
    localparam rgb_t C_BLACK   = rgb_t'(12'h000);

    // Colour-bar order, left to right across the visible line.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = C_WHITE;
            3'd1:    c = C_YELLOW;
            3'd2:    c = C_CYAN;
            3'd3:    c = C_GREEN;
            3'd4:    c = C_MAGENTA;
            3'd5:    c = C_RED;
            3'd6:    c = C_BLUE;
            default: c = C_BLACK;
        endcase
        return c;
    endfunction

    // Mode cycle used by the button: bars, checker, box, solid, back to bars.
    function automatic mode_e next_mode(input mode_e m);
        mode_e n;
        case (m)
            MODE_BARS:    n = MODE_CHECKER;
            MODE_CHECKER: n = MODE_BOX;
            MODE_BOX:     n = MODE_SOLID;
            default:      n = MODE_BARS;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// rtl/vga_box_mover.sv - bouncing box position, one step per frame
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int H_VIS = VGA_H_VIS,
    parameter int V_VIS = VGA_V_VIS,
    parameter int BOX   = VGA_BOX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    output logic [10:0] bx,
    output logic [10:0] by
);

    localparam logic [10:0] BX_MAX  = 11'(H_VIS - BOX);
    localparam logic [10:0] BY_MAX  = 11'(V_VIS - BOX);
    localparam logic [10:0] BX_INIT = 11'((H_VIS - BOX) / 2);
    localparam logic [10:0] BY_INIT = 11'((V_VIS - BOX) / 2);

    logic        dx_neg;
    logic        dy_neg;
    logic [10:0] bx_n;
    logic [10:0] by_n;

    // Candidate next position one pixel along the current direction.
    always_comb begin
        bx_n = dx_neg ? (bx - 11'd1) : (bx + 11'd1);
        by_n = dy_neg ? (by - 11'd1) : (by + 11'd1);
    end

    // Step on each frame; flip direction in the same step that touches an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            bx     <= BX_INIT;
            by     <= BY_INIT;
            dx_neg <= 1'b0;
            dy_neg <= 1'b0;
        end else if (frame_start) begin
            bx <= bx_n;
            by <= by_n;
            if (bx_n == 11'd0 || bx_n == BX_MAX) dx_neg <= ~dx_neg;
            if (by_n == 11'd0 || by_n == BY_MAX) dy_neg <= ~dy_neg;
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - two-stage VGA sync and test-pattern generator
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_VIS  = VGA_H_VIS,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_VIS  = VGA_V_VIS,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP,
    parameter int BOX    = VGA_BOX
) (
    input  logic        CLK100MHz,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        mode_btn,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic [7:0]  frame_cnt
);

    localparam logic [10:0] H_VIS_C   = 11'(H_VIS);
    localparam logic [10:0] V_VIS_C   = 11'(V_VIS);
    localparam logic [10:0] H_TOTAL_C = 11'(H_VIS + H_FP + H_SYNC + H_BP);
    localparam logic [10:0] V_TOTAL_C = 11'(V_VIS + V_FP + V_SYNC + V_BP);
    localparam logic [10:0] HS_START  = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] VS_START  = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_VIS + V_FP + V_SYNC);
    localparam logic [10:0] BAR_W     = 11'(H_VIS / 8);
    localparam logic [10:0] BOX_C     = 11'(BOX);

    logic        in_range;
    logic        vis_c;
    logic        hs_c;
    logic        vs_c;

    logic [10:0] h1;
    logic [10:0] v1;
    logic        vis1;
    logic        hs1;
    logic        vs1;
    logic        zero1;
    logic        zero_d;
    logic        frame_start;

    logic        btn_meta;
    logic        btn_sync;
    logic        btn_prev;
    logic        btn_rise;

    mode_e       mode_q;
    mode_e       mode_d;
    logic        req_q;
    logic        req_d;

    logic [10:0] bx;
    logic [10:0] by;
    logic [2:0]  bar_idx;
    logic        in_box;
    rgb_t        pix;

    // Region decode of the incoming count; anything past the frame total is blanking.
    always_comb begin
        in_range = (hcount < H_TOTAL_C) && (vcount < V_TOTAL_C);
        vis_c    = (hcount < H_VIS_C) && (vcount < V_VIS_C);
        hs_c     = in_range && (hcount >= HS_START) && (hcount < HS_END);
        vs_c     = in_range && (vcount >= VS_START) && (vcount < VS_END);
    end

    // Stage 1: capture the count and its decoded region flags.
    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            h1   <= '0;
            v1   <= '0;
            vis1 <= 1'b0;
            hs1  <= 1'b0;
            vs1  <= 1'b0;
        end else begin
            h1   <= hcount;
            v1   <= vcount;
            vis1 <= vis_c;
            hs1  <= hs_c;
            vs1  <= vs_c;
        end
    end

    // Frame boundary is the stage-1 count arriving at (0,0); reset counts as "already at 0,0".
    assign zero1       = (h1 == 11'd0) && (v1 == 11'd0);
    assign frame_start = zero1 && !zero_d;

    // Remember whether the previous stage-1 count was (0,0) so a held origin strobes once.
    always_ff @(posedge CLK100MHz) begin
        if (reset) zero_d <= 1'b1;
        else       zero_d <= zero1;
    end

    // Two-flop synchronizer for the button plus a delayed copy for edge detection.
    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            btn_meta <= mode_btn;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    assign btn_rise = btn_sync && !btn_prev;

    // Mode and pending-request registers.
    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            mode_q <= MODE_BARS;
            req_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            req_q  <= req_d;
        end
    end

    // Mode changes only at a frame boundary; an edge landing on that boundary waits a frame.
    always_comb begin
        mode_d = mode_q;
        req_d  = req_q;
        if (frame_start) begin
            if (req_q) mode_d = next_mode(mode_q);
            req_d = btn_rise;
        end else if (btn_rise) begin
            req_d = 1'b1;
        end
    end

    // Frames since reset, wrapping naturally at 8 bits.
    always_ff @(posedge CLK100MHz) begin
        if (reset)            frame_cnt <= 8'd0;
        else if (frame_start) frame_cnt <= frame_cnt + 8'd1;
    end

    vga_box_mover #(
        .H_VIS (H_VIS),
        .V_VIS (V_VIS),
        .BOX   (BOX)
    ) u_box_mover (
        .clk         (CLK100MHz),
        .reset       (reset),
        .frame_start (frame_start),
        .bx          (bx),
        .by          (by)
    );

    assign bar_idx = 3'(h1 / BAR_W);
    assign in_box  = (h1 >= bx) && (h1 < bx + BOX_C) && (v1 >= by) && (v1 < by + BOX_C);

    // Pixel colour for the current mode, forced black outside the visible area.
    always_comb begin
        pix = C_BLACK;
        case (mode_q)
            MODE_BARS:    pix = bar_colour(bar_idx);
            MODE_CHECKER: pix = (h1[5] ^ v1[5]) ? C_WHITE : C_BLACK;
            MODE_BOX:     pix = in_box ? C_WHITE : C_BLUE;
            MODE_SOLID:   pix = '{r: frame_cnt[5:2], g: frame_cnt[5:2], b: frame_cnt[5:2]};
            default:      pix = C_BLACK;
        endcase
        if (!vis1) pix = C_BLACK;
    end

    // Stage 2: register syncs and colour together so every output carries the same latency.
    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            vga_r <= 4'h0;
            vga_g <= 4'h0;
            vga_b <= 4'h0;
        end else begin
            hsync <= ~hs1;
            vsync <= ~vs1;
            vga_r <= pix.r;
            vga_g <= pix.g;
            vga_b <= pix.b;
        end
    end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning): H_VIS 640 visible px; H_FP 16; H_SYNC 96; H_BP 48; V_VIS 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; BOX 32 box side px.
REQ-002 CLK100MHz  in  1  sole clock, all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 hcount  in  11  horizontal pixel count from upstream counter; each value held several clocks.
REQ-005 vcount  in  11  vertical line count from upstream counter.
REQ-006 mode_btn  in  1  asynchronous push-button level, already debounced.
REQ-007 hsync  out  1  horizontal sync, active-low.
REQ-008 vsync  out  1  vertical sync, active-low.
REQ-009 vga_r, vga_g, vga_b  out  4 each  pixel colour.
REQ-010 frame_cnt  out  8  frames since reset, wraps 255->0.

Function
REQ-011 Stage 1 SHALL register hcount/vcount and derive: visible = h<H_VIS && v<V_VIS; hs_act = 656<=h<752; vs_act = 490<=v<492 (bounds from parameters).
REQ-012 Stage 2 SHALL register hsync=~hs_act, vsync=~vs_act, and RGB; total latency 2 clocks from count to outputs, all outputs mutually aligned.
REQ-013 RGB SHALL be 0 whenever visible=0.
REQ-014 Counts h>=800 or v>=525 SHALL be treated as blanking with syncs inactive (1).
REQ-015 frame_start SHALL be a one-clock strobe when the stage-1 count becomes (0,0) after being any other value; a held (0,0) SHALL give one strobe only.
REQ-016 Mode FSM states SHALL be BARS -> CHECKER -> BOX -> SOLID -> BARS.
REQ-017 mode_btn SHALL pass a 2-flop synchronizer; a rising edge sets a request flag; further edges while the flag is set are dropped.
REQ-018 On frame_start with request set, mode SHALL advance one state and the flag clear; an edge coinciding with frame_start SHALL be applied at the following frame_start.
REQ-019 BARS: eight 80-px bars by h/80: white, yellow, cyan, green, magenta, red, blue, black (4'hF/4'h0 components).
REQ-020 CHECKER: white if h[5]^v[5], else black.
REQ-021 BOX: white where bx<=h<bx+BOX and by<=v<by+BOX, else blue (0,0,F).
REQ-022 SOLID: r=g=b=frame_cnt[5:2].
REQ-023 Box position SHALL update every frame_start in all modes: bx += dx, by += dy (dx, dy = +/-1).
REQ-024 A direction SHALL flip in the same update when the new coordinate reaches 0 or H_VIS-BOX (608) / V_VIS-BOX (448); the coordinate never leaves this range.
REQ-025 frame_cnt SHALL increment on frame_start, modulo 256.

Reset
REQ-026 While reset=1 at a clock edge: hsync=1, vsync=1, RGB=0, frame_cnt=0, mode=BARS, request flag=0, synchronizer=0, pipeline visible=0.
REQ-027 Reset SHALL set bx=304, by=224, dx=+1, dy=+1.
REQ-028 Reset mid-frame SHALL take effect on the next edge; the first frame_start after release requires a (0,0) count following a non-(0,0) stage-1 value.

Structure
REQ-029 Timing constants, mode encoding (2-bit) and colour constants SHALL live in shared package vga_pkg, also used by the upstream counter.
REQ-030 Box position/bounce logic SHALL be sub-module vga_box_mover (inputs: clock, reset, frame_start; outputs: bx, by).

Verification
REQ-031 Drive h=0..799, v=0..524 at 4 clocks per count after reset -> hsync low exactly for h 656..751, vsync low for v 490..491, 2-clock latency.
REQ-032 BARS, count (85,10) -> RGB=(F,F,0); (639,479) -> (0,0,0); (640,10) -> (0,0,0).
REQ-033 mode_btn pulsed three times mid-frame -> mode advances exactly once at the next frame_start (BARS->CHECKER); CHECKER (32,0) -> white.
REQ-034 BOX mode, 81 frames after reset -> bx=385, by=305, dx=dy=+1; after 224 frames by=448 and dy=-1.
REQ-035 h=900, v=600 -> RGB=0, hsync=vsync=1.
REQ-036 Reset asserted mid-frame in SOLID with frame_cnt=37 -> next clock frame_cnt=0, RGB=0, mode=BARS.
